dmem_access: RTL and testbench

DMEM_ACCESS -- requirements
Module: dmem_access

---
 rtl/cpu31_pkg.sv | 54 +++++
 rtl/dmem_access_if.sv | 23 ++
 rtl/dmem_lane_ext.sv | 33 +++
 rtl/dmem_access.sv | 152 +++++++++++++++
 tb/tb_dmem_access.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu31_pkg.sv
// Shared definitions for the CPU data-memory access path: size codes, FSM states,
// the latched request control word and byte-lane helper functions.
package cpu31_pkg;

    localparam int unsigned ACK_TIMEOUT_DEF = 16;
    localparam int unsigned XLEN            = 32;
    localparam int unsigned BE_W            = XLEN / 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    typedef struct packed {
        logic       we;
        size_e      size;
        logic       sign_ext;
        logic [1:0] addr_lo;
    } dmem_ctl_t;

    // Reserved size behaves as a word everywhere
    function automatic logic [BE_W-1:0] be_gen(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] wdata_gen(input size_e sz, input logic [XLEN-1:0] d);
        case (sz)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_if.sv
// Memory-side request/acknowledge bus between the access unit (master) and memory (slave).
interface dmem_access_if;
    import cpu31_pkg::*;

    logic            mem_req;
    logic            mem_we;
    logic [BE_W-1:0] mem_be;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/dmem_lane_ext.sv
// Combinational load-lane selection (little-endian) and sign/zero extension.
module dmem_lane_ext
    import cpu31_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      addr_lo_i,
    input  size_e           size_i,
    input  logic            sign_ext_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        half_v = 16'h0000;
        data_o = word_i;
        case (addr_lo_i)
            2'd0:    byte_v = word_i[7:0];
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            default: byte_v = word_i[31:24];
        endcase
        half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_BYTE: data_o = sign_ext_i ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
            SZ_HALF: data_o = sign_ext_i ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_access.sv
// CPU data-memory access unit: latches a load/store, drives the memory bus, waits for ack
// with timeout, and returns extended load data. Optional trap: `DMEM_MISALIGN_TRAP_EN.
module dmem_access
    import cpu31_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            we,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic            err,
    output logic            misalign,
    dmem_access_if.master   mem
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    dmem_ctl_t       ctl_q;
    dmem_ctl_t       ctl_d;
    size_e           size_d;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [XLEN-1:0] rdata_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [BE_W-1:0] mem_be_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [XLEN-1:0] lane_data;
    logic            timeout_hit;

    assign size_d      = size_e'(size);
    assign ctl_d       = '{we: we, size: size_d, sign_ext: sign_ext, addr_lo: addr[1:0]};
    assign timeout_hit = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misal_q;
    logic misal_d;
    assign misal_d  = is_misaligned(size_d, addr[1:0]);
    assign misalign = misal_q;
`else
    assign misalign = 1'b0;
`endif

    dmem_lane_ext u_lane_ext (
        .word_i     (mem.mem_rdata),
        .addr_lo_i  (ctl_q.addr_lo),
        .size_i     (ctl_q.size),
        .sign_ext_i (ctl_q.sign_ext),
        .data_o     (lane_data)
    );

    // Access FSM; every output is a register updated on the transition that defines it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ctl_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
            misal_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        ctl_q  <= ctl_d;
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
                        if (misal_d) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            misal_q <= 1'b1;
                            rdata_q <= '0;
                        end else
`endif
                        begin
                            state_q     <= ST_ACCESS;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= we;
                            mem_be_q    <= be_gen(size_d, addr[1:0]);
                            mem_addr_q  <= {addr[XLEN-1:2], 2'b00};
                            mem_wdata_q <= wdata_gen(size_d, wdata);
                        end
                    end
                end
                ST_ACCESS: begin
                    // Ack beats a timeout landing on the same cycle
                    if (mem.mem_ack) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                        rdata_q   <= ctl_q.we ? '0 : lane_data;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
                    misal_q <= 1'b0;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign rdata         = rdata_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access.sv
// Directed self-checking bench for dmem_access (default ACK_TIMEOUT of 16).
module tb_dmem_access;
    import cpu31_pkg::*;

    logic        clk = 1'b0;
    logic        rst, req, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, done, err, misalign;
    logic [31:0] rdata;
    int          n_cmp = 0;
    int          n_bad = 0;

    dmem_access_if m();

    dmem_access #(.ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .err(err), .misalign(misalign), .mem(m)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then scramble the inputs to expose any missing latch
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        step();
        req = 1'b0; we = ~w; size = ~sz; sign_ext = ~sx; addr = ~a; wdata = ~d;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0; m.mem_ack = 1'b0; m.mem_rdata = 32'h0;
        step(); step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b exp 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b exp 0", err); end
        n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL rst_misalign: got %b exp 0", misalign); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h exp 0", rdata); end
        n_cmp++; if (m.mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %b exp 0", m.mem_req); end
        n_cmp++; if (m.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b exp 0", m.mem_we); end
        n_cmp++; if (m.mem_be !== 4'h0) begin n_bad++; $display("FAIL rst_mem_be: got %b exp 0000", m.mem_be); end
        n_cmp++; if (m.mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h exp 0", m.mem_addr); end
        n_cmp++; if (m.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h exp 0", m.mem_wdata); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_loads();
        logic [1:0]  t_sz [7] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11};
        logic        t_sx [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] t_a  [7] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h100, 32'h201, 32'h204};
        logic [31:0] t_rd [7] = '{32'hDEADBEEF, 32'h80000000, 32'h80000000, 32'h80011234,
                                  32'h80019234, 32'h11227F44, 32'hCAFEF00D};
        logic [3:0]  t_be [7] = '{4'b1111, 4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111};
        logic [31:0] t_ex [7] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
                                  32'h00009234, 32'h0000007F, 32'hCAFEF00D};
        logic [31:0] wa;
        for (int i = 0; i < 7; i++) begin
            wa = {t_a[i][31:2], 2'b00};
            issue(1'b0, t_sz[i], t_sx[i], t_a[i], 32'h0);
            n_cmp++; if (m.mem_req !== 1'b1) begin n_bad++; $display("FAIL ld%0d_mem_req: got %b exp 1", i, m.mem_req); end
            n_cmp++; if (m.mem_we !== 1'b0) begin n_bad++; $display("FAIL ld%0d_mem_we: got %b exp 0", i, m.mem_we); end
            n_cmp++; if (m.mem_be !== t_be[i]) begin n_bad++; $display("FAIL ld%0d_mem_be: got %b exp %b", i, m.mem_be, t_be[i]); end
            n_cmp++; if (m.mem_addr !== wa) begin n_bad++; $display("FAIL ld%0d_mem_addr: got %h exp %h", i, m.mem_addr, wa); end
            n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL ld%0d_access: busy %b done %b exp 1 0", i, busy, done); end
            m.mem_ack = 1'b1; m.mem_rdata = t_rd[i];
            step();
            m.mem_ack = 1'b0; m.mem_rdata = 32'h5A5A5A5A;
            n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ld%0d_done: got %b exp 1", i, done); end
            n_cmp++; if (rdata !== t_ex[i]) begin n_bad++; $display("FAIL ld%0d_rdata: got %h exp %h", i, rdata, t_ex[i]); end
            n_cmp++; if (err !== 1'b0 || misalign !== 1'b0) begin n_bad++; $display("FAIL ld%0d_flags: err %b misalign %b exp 0 0", i, err, misalign); end
            n_cmp++; if (m.mem_req !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL ld%0d_done_state: mem_req %b busy %b exp 0 1", i, m.mem_req, busy); end
            step();
            n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL ld%0d_idle: done %b busy %b exp 0 0", i, done, busy); end
            n_cmp++; if (rdata !== t_ex[i]) begin n_bad++; $display("FAIL ld%0d_rdata_hold: got %h exp %h", i, rdata, t_ex[i]); end
        end
    endtask

    task automatic test_stores();
        logic [1:0]  t_sz [3] = '{2'b01, 2'b00, 2'b10};
        logic [31:0] t_a  [3] = '{32'h102, 32'h101, 32'h104};
        logic [31:0] t_d  [3] = '{32'h1234ABCD, 32'h00000055, 32'h89ABCDEF};
        logic [3:0]  t_be [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] t_wd [3] = '{32'hABCDABCD, 32'h55555555, 32'h89ABCDEF};
        logic [31:0] wa;
        for (int i = 0; i < 3; i++) begin
            wa = {t_a[i][31:2], 2'b00};
            issue(1'b1, t_sz[i], 1'b1, t_a[i], t_d[i]);
            n_cmp++; if (m.mem_we !== 1'b1) begin n_bad++; $display("FAIL st%0d_mem_we: got %b exp 1", i, m.mem_we); end
            n_cmp++; if (m.mem_be !== t_be[i]) begin n_bad++; $display("FAIL st%0d_mem_be: got %b exp %b", i, m.mem_be, t_be[i]); end
            n_cmp++; if (m.mem_wdata !== t_wd[i]) begin n_bad++; $display("FAIL st%0d_mem_wdata: got %h exp %h", i, m.mem_wdata, t_wd[i]); end
            n_cmp++; if (m.mem_addr !== wa) begin n_bad++; $display("FAIL st%0d_mem_addr: got %h exp %h", i, m.mem_addr, wa); end
            m.mem_ack = 1'b1; m.mem_rdata = 32'hFFFFFFFF;
            step();
            m.mem_ack = 1'b0;
            n_cmp++; if (done !== 1'b1 || rdata !== 32'h0) begin n_bad++; $display("FAIL st%0d_done: done %b rdata %h exp 1 00000000", i, done, rdata); end
            step();
        end
    endtask

    task automatic test_timeout();
        // Abort: 16 ACCESS cycles with no ack; rdata previously nonzero must clear
        m.mem_rdata = 32'h11111111;
        issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        for (int i = 1; i <= 15; i++) begin
            step();
            n_cmp++; if (m.mem_req !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL to_wait%0d: mem_req %b done %b exp 1 0", i, m.mem_req, done); end
        end
        step();
        n_cmp++; if (done !== 1'b1 || err !== 1'b1) begin n_bad++; $display("FAIL to_abort: done %b err %b exp 1 1", done, err); end
        n_cmp++; if (rdata !== 32'h0 || m.mem_req !== 1'b0) begin n_bad++; $display("FAIL to_abort_data: rdata %h mem_req %b exp 0 0", rdata, m.mem_req); end
        step();
        n_cmp++; if (err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL to_idle: err %b busy %b exp 0 0", err, busy); end
        // Ack on the 16th ACCESS cycle completes normally
        issue(1'b0, 2'b10, 1'b0, 32'h304, 32'h0);
        for (int i = 1; i <= 15; i++) step();
        m.mem_ack = 1'b1; m.mem_rdata = 32'h0BADF00D;
        step();
        m.mem_ack = 1'b0;
        n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL to_late_ack: done %b err %b exp 1 0", done, err); end
        n_cmp++; if (rdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL to_late_rdata: got %h exp 0badf00d", rdata); end
        step();
    endtask

    task automatic test_ignored();
        m.mem_ack = 1'b1; m.mem_rdata = 32'h12345678;
        step(); step();
        m.mem_ack = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || m.mem_req !== 1'b0) begin n_bad++; $display("FAIL ign_idle_ack: busy %b done %b mem_req %b exp 0 0 0", busy, done, m.mem_req); end
        n_cmp++; if (rdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL ign_idle_rdata: got %h exp 0badf00d", rdata); end
        issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        req = 1'b1; addr = 32'h500;
        step();
        n_cmp++; if (m.mem_addr !== 32'h400) begin n_bad++; $display("FAIL ign_busy_addr: got %h exp 00000400", m.mem_addr); end
        m.mem_ack = 1'b1; m.mem_rdata = 32'h00000400;
        step();
        m.mem_ack = 1'b0; req = 1'b0;
        step(); step();
        n_cmp++; if (busy !== 1'b0 || m.mem_req !== 1'b0) begin n_bad++; $display("FAIL ign_not_queued: busy %b mem_req %b exp 0 0", busy, m.mem_req); end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (m.mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rm_abandon: mem_req %b busy %b done %b exp 0 0 0", m.mem_req, busy, done); end
        m.mem_ack = 1'b1; m.mem_rdata = 32'hFFFF0000;
        step();
        m.mem_ack = 1'b0;
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rm_no_done: done %b busy %b exp 0 0", done, busy); end
        issue(1'b0, 2'b10, 1'b0, 32'h604, 32'h0);
        m.mem_ack = 1'b1; m.mem_rdata = 32'h600DCAFE;
        step();
        m.mem_ack = 1'b0;
        n_cmp++; if (done !== 1'b1 || rdata !== 32'h600DCAFE) begin n_bad++; $display("FAIL rm_recover: done %b rdata %h exp 1 600dcafe", done, rdata); end
        step();
    endtask

    task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
        issue(1'b0, 2'b01, 1'b1, 32'h101, 32'h0);
        n_cmp++; if (m.mem_req !== 1'b0) begin n_bad++; $display("FAIL ma_lh_no_req: got %b exp 0", m.mem_req); end
        n_cmp++; if (done !== 1'b1 || misalign !== 1'b1) begin n_bad++; $display("FAIL ma_lh_flag: done %b misalign %b exp 1 1", done, misalign); end
        n_cmp++; if (rdata !== 32'h0 || err !== 1'b0) begin n_bad++; $display("FAIL ma_lh_data: rdata %h err %b exp 0 0", rdata, err); end
        step();
        n_cmp++; if (done !== 1'b0 || misalign !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL ma_lh_idle: done %b misalign %b busy %b exp 0 0 0", done, misalign, busy); end
        issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678);
        n_cmp++; if (m.mem_req !== 1'b0 || misalign !== 1'b1) begin n_bad++; $display("FAIL ma_sw: mem_req %b misalign %b exp 0 1", m.mem_req, misalign); end
        step();
`else
        issue(1'b0, 2'b01, 1'b1, 32'h101, 32'h0);
        n_cmp++; if (m.mem_req !== 1'b1 || m.mem_be !== 4'b0011) begin n_bad++; $display("FAIL ma_lh_lanes: mem_req %b mem_be %b exp 1 0011", m.mem_req, m.mem_be); end
        m.mem_ack = 1'b1; m.mem_rdata = 32'hABCD8001;
        step();
        m.mem_ack = 1'b0;
        n_cmp++; if (rdata !== 32'hFFFF8001 || misalign !== 1'b0) begin n_bad++; $display("FAIL ma_lh_data: rdata %h misalign %b exp ffff8001 0", rdata, misalign); end
        step();
        issue(1'b0, 2'b10, 1'b0, 32'h103, 32'h0);
        n_cmp++; if (m.mem_be !== 4'b1111 || m.mem_addr !== 32'h100) begin n_bad++; $display("FAIL ma_lw_lanes: mem_be %b mem_addr %h exp 1111 00000100", m.mem_be, m.mem_addr); end
        m.mem_ack = 1'b1; m.mem_rdata = 32'h76543210;
        step();
        m.mem_ack = 1'b0;
        n_cmp++; if (rdata !== 32'h76543210 || misalign !== 1'b0) begin n_bad++; $display("FAIL ma_lw_data: rdata %h misalign %b exp 76543210 0", rdata, misalign); end
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_timeout();
        test_ignored();
        test_reset_mid();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
